// File: rtl/ifu_fetch_bridge.sv
// IFU fetch bridge: turns one IFU fetch request into one DDR read burst and returns a 128-bit block.
// Optional one-entry line buffer enabled by defining FETCH_BRIDGE_LINEBUF_EN.
module ifu_fetch_bridge #(
    parameter int ADDR_W     = 64,
    parameter int DDR_DATA_W = 64,
    parameter int BEATS      = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  pc_index_valid,
    output logic                  pc_index_ready,
    input  logic [ADDR_W-1:0]     pc_index,
    output logic                  pc_operation_done,
    output logic [127:0]          pc_read_inst,
    input  logic                  redirect_valid,
    output logic                  ddr_req_valid,
    input  logic                  ddr_req_ready,
    output logic [ADDR_W-1:0]     ddr_req_addr,
    input  logic                  ddr_rsp_valid,
    input  logic [DDR_DATA_W-1:0] ddr_rsp_data
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [127:0]       asm_q, asm_d;
    logic [127:0]       out_q, out_d;
    logic               flush_pend_q, flush_pend_d;
    logic [ADDR_W-1:0]  aligned_s;
    logic               last_beat_s;
    logic               lb_hit_s;

    assign aligned_s   = pc_index & {{(ADDR_W-4){1'b1}}, 4'b0000};
    assign last_beat_s = (beat_cnt_q == CNT_W'(BEATS-1));

`ifdef FETCH_BRIDGE_LINEBUF_EN
    // The line data is exactly the last delivered block, so out_q doubles as the buffer data.
    logic              lb_valid_q, lb_valid_d;
    logic [ADDR_W-1:0] lb_addr_q, lb_addr_d;

    assign lb_hit_s = lb_valid_q && (lb_addr_q == aligned_s);
`else
    assign lb_hit_s = 1'b0;
`endif

    // Next-state, datapath updates and handshake outputs
    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        beat_cnt_d        = beat_cnt_q;
        asm_d             = asm_q;
        out_d             = out_q;
        flush_pend_d      = flush_pend_q;
        pc_index_ready    = 1'b0;
        pc_operation_done = 1'b0;
        ddr_req_valid     = 1'b0;
`ifdef FETCH_BRIDGE_LINEBUF_EN
        lb_valid_d        = lb_valid_q;
        lb_addr_d         = lb_addr_q;
`endif
        case (state_q)
            IDLE: begin
                pc_index_ready = !redirect_valid;
                if (pc_index_valid && !redirect_valid) begin
                    addr_d       = aligned_s;
                    flush_pend_d = 1'b0;
                    if (lb_hit_s) begin
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                ddr_req_valid = 1'b1;
                if (redirect_valid) begin
                    flush_pend_d = 1'b1;
                end else begin
                    flush_pend_d = flush_pend_q;
                end
                if (ddr_req_ready) begin
                    state_d    = RESP;
                    beat_cnt_d = {CNT_W{1'b0}};
                end else begin
                    state_d = REQ;
                end
            end
            RESP: begin
                if (redirect_valid) begin
                    flush_pend_d = 1'b1;
                end else begin
                    flush_pend_d = flush_pend_q;
                end
                if (ddr_rsp_valid) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (beat_cnt_q == CNT_W'(b)) begin
                            asm_d[b*DDR_DATA_W +: DDR_DATA_W] = ddr_rsp_data;
                        end else begin
                            asm_d[b*DDR_DATA_W +: DDR_DATA_W] = asm_q[b*DDR_DATA_W +: DDR_DATA_W];
                        end
                    end
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (last_beat_s) begin
                        if (flush_pend_q || redirect_valid) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DONE;
                            out_d   = asm_d;
`ifdef FETCH_BRIDGE_LINEBUF_EN
                            lb_valid_d = 1'b1;
                            lb_addr_d  = addr_q;
`endif
                        end
                    end else begin
                        state_d = RESP;
                    end
                end else begin
                    state_d = RESP;
                end
            end
            DONE: begin
                pc_operation_done = !redirect_valid;
                state_d           = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef FETCH_BRIDGE_LINEBUF_EN
        // Any redirect invalidates the buffered line, overriding a fill in the same cycle.
        if (redirect_valid) begin
            lb_valid_d = 1'b0;
        end else begin
            lb_valid_d = lb_valid_d;
        end
`endif
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= {ADDR_W{1'b0}};
            beat_cnt_q   <= {CNT_W{1'b0}};
            asm_q        <= 128'd0;
            out_q        <= 128'd0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            beat_cnt_q   <= beat_cnt_d;
            asm_q        <= asm_d;
            out_q        <= out_d;
            flush_pend_q <= flush_pend_d;
        end
    end

`ifdef FETCH_BRIDGE_LINEBUF_EN
    // Line buffer tag registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lb_valid_q <= 1'b0;
            lb_addr_q  <= {ADDR_W{1'b0}};
        end else begin
            lb_valid_q <= lb_valid_d;
            lb_addr_q  <= lb_addr_d;
        end
    end
`endif

    assign ddr_req_addr = addr_q;
    assign pc_read_inst = out_q;

endmodule

// File: tb/tb_ifu_fetch_bridge.sv
// Randomized self-checking bench for ifu_fetch_bridge against a transaction-level fetch model.
module tb_ifu_fetch_bridge;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         pc_index_valid = 1'b0;
    logic         pc_index_ready;
    logic [63:0]  pc_index = 64'd0;
    logic         pc_operation_done;
    logic [127:0] pc_read_inst;
    logic         redirect_valid = 1'b0;
    logic         ddr_req_valid;
    logic         ddr_req_ready = 1'b0;
    logic [63:0]  ddr_req_addr;
    logic         ddr_rsp_valid = 1'b0;
    logic [63:0]  ddr_rsp_data = 64'd0;

    ifu_fetch_bridge #(.ADDR_W(64), .DDR_DATA_W(64), .BEATS(2)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .pc_index_valid    (pc_index_valid),
        .pc_index_ready    (pc_index_ready),
        .pc_index          (pc_index),
        .pc_operation_done (pc_operation_done),
        .pc_read_inst      (pc_read_inst),
        .redirect_valid    (redirect_valid),
        .ddr_req_valid     (ddr_req_valid),
        .ddr_req_ready     (ddr_req_ready),
        .ddr_req_addr      (ddr_req_addr),
        .ddr_rsp_valid     (ddr_rsp_valid),
        .ddr_rsp_data      (ddr_rsp_data)
    );

    always #5 clock = ~clock;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [127:0] exp_inst = 128'd0;
    bit           lb_valid = 1'b0;
    logic [59:0]  lb_tag   = 60'd0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // mode: 0 none, 1 redirect in first REQ cycle, 2 redirect in cycle after beat 0, 3 redirect in DONE cycle
    task automatic fetch(input logic [63:0] pc, input int delay, input int gap0, input int gap1,
                         input int mode, input logic [63:0] b0, input logic [63:0] b1);
        logic [63:0] a;
        bit          hit;
        bit          flushed;
        int          m;
        int          g;
        a = {pc[63:4], 4'h0};
        m = mode;
`ifdef FETCH_BRIDGE_LINEBUF_EN
        hit = lb_valid && (lb_tag == pc[63:4]);
`else
        hit = 1'b0;
`endif
        if (hit) m = 0;
        pc_index_valid = 1'b1;
        pc_index       = pc;
        @(negedge clock);
        check_eq("hs_ready", pc_index_ready, 1'b1);
        next_cycle();
        pc_index_valid = 1'b0;
        pc_index       = rnd64();
        if (hit) begin
            @(negedge clock);
            check_eq("lb_noreq", ddr_req_valid, 1'b0);
            check_eq("lb_done", pc_operation_done, 1'b1);
            check_eq("lb_data", pc_read_inst, exp_inst);
            next_cycle();
            return;
        end
        for (int i = 0; i <= delay; i++) begin
            ddr_req_ready  = (i == delay);
            redirect_valid = (m == 1 && i == 0);
            @(negedge clock);
            check_eq("req_valid", ddr_req_valid, 1'b1);
            check_eq("req_addr", ddr_req_addr, a);
            check_eq("req_busy", pc_index_ready, 1'b0);
            check_eq("req_nodone", pc_operation_done, 1'b0);
            next_cycle();
        end
        ddr_req_ready  = 1'b0;
        redirect_valid = 1'b0;
        flushed = (m == 1);
        for (int bt = 0; bt < 2; bt++) begin
            g = (bt == 0) ? gap0 : gap1;
            for (int i = 0; i <= g; i++) begin
                ddr_rsp_valid  = (i == g);
                ddr_rsp_data   = (i == g) ? ((bt == 0) ? b0 : b1) : rnd64();
                redirect_valid = (m == 2 && bt == 1 && i == 0);
                @(negedge clock);
                check_eq("resp_nodone", pc_operation_done, 1'b0);
                check_eq("resp_noreq", ddr_req_valid, 1'b0);
                check_eq("resp_busy", pc_index_ready, 1'b0);
                next_cycle();
            end
        end
        ddr_rsp_valid  = 1'b0;
        ddr_rsp_data   = rnd64();
        redirect_valid = 1'b0;
        if (m == 2) flushed = 1'b1;
        if (flushed) begin
            lb_valid = 1'b0;
            @(negedge clock);
            check_eq("flush_nodone", pc_operation_done, 1'b0);
            check_eq("flush_hold", pc_read_inst, exp_inst);
            check_eq("flush_idle", pc_index_ready, 1'b1);
        end else begin
            exp_inst       = {b1, b0};
            redirect_valid = (m == 3);
            @(negedge clock);
            check_eq("done", pc_operation_done, (m != 3));
            check_eq("data", pc_read_inst, exp_inst);
            check_eq("done_busy", pc_index_ready, 1'b0);
            next_cycle();
            redirect_valid = 1'b0;
            if (m == 3) begin
                lb_valid = 1'b0;
            end else begin
                lb_valid = 1'b1;
                lb_tag   = pc[63:4];
            end
            @(negedge clock);
            check_eq("post_idle", pc_index_ready, 1'b1);
            check_eq("post_nodone", pc_operation_done, 1'b0);
            check_eq("post_noreq", ddr_req_valid, 1'b0);
        end
        next_cycle();
    endtask

    task automatic redirect_in_idle(input logic [63:0] pc);
        pc_index_valid = 1'b1;
        pc_index       = pc;
        redirect_valid = 1'b1;
        lb_valid       = 1'b0;
        @(negedge clock);
        check_eq("rdr_ready", pc_index_ready, 1'b0);
        next_cycle();
        pc_index_valid = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clock);
        check_eq("rdr_noreq", ddr_req_valid, 1'b0);
        check_eq("rdr_nodone", pc_operation_done, 1'b0);
        next_cycle();
    endtask

    initial begin
        logic [63:0] pc;
        int          mode;
        #3;
        check_eq("rst_req", ddr_req_valid, 1'b0);
        check_eq("rst_done", pc_operation_done, 1'b0);
        check_eq("rst_inst", pc_read_inst, 128'd0);
        check_eq("rst_addr", ddr_req_addr, 64'd0);
        next_cycle();
        reset_n = 1'b1;
        next_cycle();

        fetch(64'h0000_0000_8000_0004, 0, 0, 0, 0, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
        check_eq("basic_block", exp_inst, 128'h5555_6666_7777_8888_1111_2222_3333_4444);
        fetch(64'h0000_0001_2345_6788, 5, 0, 0, 0, rnd64(), rnd64());
        fetch(64'h0000_0000_9000_0010, 0, 0, 1, 2, rnd64(), rnd64());
        fetch(64'h0000_0000_9000_0020, 1, 0, 0, 1, rnd64(), rnd64());
        fetch(64'h0000_0000_9000_0030, 0, 1, 0, 3, rnd64(), rnd64());
        redirect_in_idle(64'h0000_0000_9000_0040);

        fetch(64'h0000_0000_8000_0000, 0, 0, 0, 0, rnd64(), rnd64());
        fetch(64'h0000_0000_8000_0008, 0, 0, 0, 0, rnd64(), rnd64());
        redirect_in_idle(64'h0000_0000_8000_0008);
        fetch(64'h0000_0000_8000_0008, 0, 0, 0, 0, rnd64(), rnd64());

        // Async reset in the middle of a burst, then stray beats.
        pc_index_valid = 1'b1;
        pc_index       = 64'h0000_0000_A000_0000;
        next_cycle();
        pc_index_valid = 1'b0;
        ddr_req_ready  = 1'b1;
        next_cycle();
        ddr_req_ready  = 1'b0;
        ddr_rsp_valid  = 1'b1;
        ddr_rsp_data   = rnd64();
        next_cycle();
        ddr_rsp_valid  = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_req", ddr_req_valid, 1'b0);
        check_eq("arst_done", pc_operation_done, 1'b0);
        check_eq("arst_inst", pc_read_inst, 128'd0);
        check_eq("arst_addr", ddr_req_addr, 64'd0);
        check_eq("arst_ready", pc_index_ready, 1'b1);
        exp_inst = 128'd0;
        lb_valid = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ddr_rsp_valid = 1'b1;
            ddr_rsp_data  = rnd64();
            @(negedge clock);
            check_eq("stray_nodone", pc_operation_done, 1'b0);
            check_eq("stray_noreq", ddr_req_valid, 1'b0);
            check_eq("stray_inst", pc_read_inst, 128'd0);
            next_cycle();
        end
        ddr_rsp_valid = 1'b0;

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) < 5) begin
                pc = 64'h0000_0000_8000_0000 + 64'($urandom_range(0, 63));
            end else begin
                pc = rnd64();
            end
            mode = $urandom_range(0, 6);
            if (mode > 3) mode = 0;
            if ($urandom_range(0, 9) == 0) begin
                redirect_in_idle(pc);
            end else begin
                fetch(pc, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
                      mode, rnd64(), rnd64());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
